booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier for the datapath MULT/MULTU path. It is the next generation of the current fixed 32-bit signed unit.
- Adds:
  - a WIDTH parameter;
  - a per-operation signed/unsigned mode;
  - a clean start/busy/done handshake;
  - a synchronous abort.
- The result lands in the hi/lo registers read by MFHI/MFLO. The control FSM stalls on busy.

Parameters:
- WIDTH, 32: operand width in bits, legal range 2..64. Product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+2): localparam, iteration counter width. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with start
- abort  in  1  synchronous cancel; returns to IDLE without writing hi/lo
- entradaA  in  WIDTH  multiplicand; latched with start
- entradaB  in  WIDTH  multiplier; latched with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result just written to hi/lo
- hi  out  WIDTH  upper half of product (registered)
- lo  out  WIDTH  lower half of product (registered)

Behaviour:
- Reset values (async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, working registers=0.
- States:
  - IDLE: start=1 at edge E0 latches operands and moves to RUN with count=0.
  - RUN: one Booth step per edge.
  - There is no separate DONE state. done is a registered pulse.
- Operand extension: both operands are extended to WIDTH+1 bits, sign-extended if is_signed, zero-extended otherwise. This lets a single signed Booth datapath serve both modes.
- Working register P is {A_acc[WIDTH+1:0], Q[WIDTH:0], q_1}, initialised to {0, B_ext, 0}.
- Per step, inspect {Q[0], q_1}:
  - 10: A_acc -= M_ext.
  - 01: A_acc += M_ext.
  - 00 or 11: no change.
  - Then arithmetic-shift the whole P right by 1, replicating the MSB.
  - M_ext is sign-extended to WIDTH+2 bits, so the add/sub never overflows.
- Iteration count is exactly WIDTH+1 steps. Steps occur at edges E1..E(WIDTH+1).
- On edge E(WIDTH+1):
  - {hi, lo} <= low 2*WIDTH bits of the product.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency from the start edge to done high is WIDTH+1 cycles (33 for WIDTH=32). Throughput is one op per WIDTH+2 cycles.
- done deasserts on the next edge. A start sampled while done=1 is accepted, since state is IDLE.
- hi/lo change only on completion. Between ops they hold the last result.
- start during RUN is ignored. Operand or mode changes during RUN have no effect.
- abort:
  - In RUN: go to IDLE at the next edge, busy=0, done stays 0, hi/lo unchanged.
  - In IDLE: no effect, and it overrides a simultaneous start (start not accepted).
- Reset mid-operation: immediate return to the reset values. hi/lo are cleared.
- WIDTH=2 edge case must work: 3 steps, 4-bit product.

Decomposition:
- Package mult_pkg holds:
  - state enum {IDLE, RUN};
  - function ext_operand(value, is_signed, width) for sign/zero extension.
- Sub-module booth_step: combinational. Input P and M_ext; output next P, i.e. add/sub by the Booth pair, then arithmetic shift. Parametrised by WIDTH.
- The top module holds the FSM, counter, operand latches and hi/lo.

Test Plan:
- WIDTH=32, signed, A=-3 (0xFFFFFFFD), B=5 -> done at cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 33 cycles.
- WIDTH=32, unsigned, A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands signed -> hi=0, lo=1.
- WIDTH=32, signed, A=B=0x80000000 -> hi=0x40000000, lo=0.
  - Then start held high through the run, operands changed mid-run -> result unaffected.
  - Back-to-back start on the done cycle -> second result after another 33 cycles.
- Abort at cycle 10 of a run following a completed 7*6 -> no done pulse, hi=0, lo=42 retained. Async reset at cycle 5 of a run -> hi=lo=0, busy=0 immediately.
- WIDTH=8, exhaustive over all 65536 operand pairs in both modes -> {hi, lo} matches a reference model every time; done always 9 cycles after start.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package mult_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int unsigned MAX_WIDTH = 64;

    // Extends the low `width` bits of value to MAX_WIDTH+2 bits.
    // Callers truncate the result to the width they need.
    function automatic logic [MAX_WIDTH+1:0] ext_operand(
        input logic [MAX_WIDTH-1:0] value,
        input logic                 is_signed,
        input int unsigned          width
    );
        logic [MAX_WIDTH+1:0] padded;
        logic [MAX_WIDTH+1:0] result;
        logic                 fill;
        padded = {2'b00, value};
        fill   = is_signed & padded[width-1];
        result = '0;
        for (int unsigned i = 0; i < MAX_WIDTH + 2; i++) begin
            result[i] = (i < width) ? padded[i] : fill;
        end
        return result;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract by the {Q[0], q_1} pair, then arithmetic shift right.
module booth_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH+3:0] p,
    input  logic [WIDTH+1:0]   m_ext,
    output logic [2*WIDTH+3:0] p_next
);

    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] acc_upd;

    assign acc = p[2*WIDTH+3:WIDTH+2];

    always_comb begin
        acc_upd = acc;
        case (p[1:0])
            2'b10:   acc_upd = acc - m_ext;
            2'b01:   acc_upd = acc + m_ext;
            default: acc_upd = acc;
        endcase
        // Old Q[0] falls into q_1; the accumulator MSB is replicated.
        p_next = {acc_upd[WIDTH+1], acc_upd, p[WIDTH+1:1]};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, with start/busy/done and abort.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] entradaA,
    input  logic [WIDTH-1:0] entradaB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    localparam int unsigned P_W   = 2 * WIDTH + 4;
    localparam int unsigned M_W   = WIDTH + 2;
    localparam int unsigned B_W   = WIDTH + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   p;
    logic [P_W-1:0]   p_next;
    logic [M_W-1:0]   m_ext;
    logic             load;
    logic             step;
    logic             finish;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .p      (p),
        .m_ext  (m_ext),
        .p_next (p_next)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(WIDTH)) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            cnt   <= '0;
            p     <= '0;
            m_ext <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (load) begin
                m_ext <= M_W'(ext_operand(64'(entradaA), is_signed, WIDTH));
                p     <= {{M_W{1'b0}}, B_W'(ext_operand(64'(entradaB), is_signed, WIDTH)), 1'b0};
                cnt   <= '0;
            end else if (step) begin
                p   <= p_next;
                cnt <= cnt + CNT_W'(1);
            end
            // Product is {A_acc, Q} after the last shift; q_1 at bit 0 is dropped.
            if (finish) begin
                {hi, lo} <= p_next[2*WIDTH:1];
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at WIDTH 32, 8 and 2 sharing one input bus, checked against an arithmetic model.
module tb_booth_mult_seq;

    localparam int NDUT = 3;
    localparam int WID [NDUT] = '{32, 8, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a_bus = '0;
    logic [31:0] b_bus = '0;

    logic        busy32, done32, busy8, done8, busy2, done2;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic [1:0]  hi2, lo2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .abort(abort),
        .entradaA(a_bus), .entradaB(b_bus), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );
    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .abort(abort),
        .entradaA(a_bus[7:0]), .entradaB(b_bus[7:0]), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );
    booth_mult_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .abort(abort),
        .entradaA(a_bus[1:0]), .entradaB(b_bus[1:0]), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2)
    );

    logic [31:0] d_hi [NDUT];
    logic [31:0] d_lo [NDUT];
    logic        d_busy [NDUT];
    logic        d_done [NDUT];
    assign d_hi[0] = hi32;           assign d_lo[0] = lo32;
    assign d_hi[1] = {24'd0, hi8};   assign d_lo[1] = {24'd0, lo8};
    assign d_hi[2] = {30'd0, hi2};   assign d_lo[2] = {30'd0, lo2};
    assign d_busy[0] = busy32; assign d_busy[1] = busy8; assign d_busy[2] = busy2;
    assign d_done[0] = done32; assign d_done[1] = done8; assign d_done[2] = done2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Plain arithmetic: extend both operands to 128 bits and keep the low 2*w bits of the product.
    function automatic logic [127:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                              input logic s, input int w);
        logic [127:0] mask, ea, eb;
        mask = (128'd1 << w) - 128'd1;
        ea = {96'd0, a} & mask;
        eb = {96'd0, b} & mask;
        if (s && ea[w-1]) ea = ea | ~mask;
        if (s && eb[w-1]) eb = eb | ~mask;
        return (ea * eb) & ((128'd1 << (2 * w)) - 128'd1);
    endfunction

    // Model: an accepted op finishes w+1 edges later; abort cancels; result held otherwise.
    bit           m_run  [NDUT];
    bit           m_done [NDUT];
    int           m_left [NDUT];
    logic [127:0] m_prod [NDUT];
    logic [127:0] m_hl   [NDUT];

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
                m_run[k]  <= 1'b0;
                m_done[k] <= 1'b0;
                m_left[k] <= 0;
                m_prod[k] <= '0;
                m_hl[k]   <= '0;
            end else if (!m_run[k]) begin
                m_done[k] <= 1'b0;
                if (start && !abort) begin
                    m_run[k]  <= 1'b1;
                    m_left[k] <= WID[k] + 1;
                    m_prod[k] <= ref_prod(a_bus, b_bus, is_signed, WID[k]);
                end
            end else if (abort) begin
                m_run[k]  <= 1'b0;
                m_done[k] <= 1'b0;
            end else if (m_left[k] == 1) begin
                m_run[k]  <= 1'b0;
                m_done[k] <= 1'b1;
                m_hl[k]   <= m_prod[k];
            end else begin
                m_left[k] <= m_left[k] - 1;
                m_done[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            logic [127:0] mask;
            mask = (128'd1 << WID[k]) - 128'd1;
            check($sformatf("busy_w%0d", WID[k]), 128'(d_busy[k]), 128'(m_run[k]));
            check($sformatf("done_w%0d", WID[k]), 128'(d_done[k]), 128'(m_done[k]));
            check($sformatf("hi_w%0d", WID[k]), 128'(d_hi[k]), (m_hl[k] >> WID[k]) & mask);
            check($sformatf("lo_w%0d", WID[k]), 128'(d_lo[k]), m_hl[k] & mask);
        end
    end

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        if (busy32) bcnt++;
        while (!done32 && lat < 100) begin
            @(posedge clk); #2;
            lat++;
            if (busy32) bcnt++;
        end
        check("done_timeout", 128'(lat < 100), 128'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output int bcnt);
        a_bus = a; b_bus = b; is_signed = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat, bcnt);
    endtask

    initial begin
        int  lat, bcnt;
        bit  seen_done;

        check("model_neg3x5",  ref_prod(32'hFFFFFFFD, 32'd5, 1'b1, 32), 128'hFFFFFFFF_FFFFFFF1);
        check("model_ffx_u32", ref_prod(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32), 128'hFFFFFFFE_00000001);
        check("model_ffx_s8",  ref_prod(32'hFF, 32'hFF, 1'b1, 8), 128'h0001);
        check("model_ffx_u8",  ref_prod(32'hFF, 32'hFF, 1'b0, 8), 128'hFE01);
        check("model_w2_s",    ref_prod(32'h2, 32'h3, 1'b1, 2), 128'h2);
        check("model_w2_u",    ref_prod(32'h2, 32'h3, 1'b0, 2), 128'h6);

        #17;
        check("reset_hi", 128'(hi32), 128'd0);
        check("reset_lo", 128'(lo32), 128'd0);
        check("reset_busy", 128'(busy32), 128'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        run_op(32'hFFFFFFFD, 32'd5, 1'b1, lat, bcnt);
        check("neg3x5_latency", 128'(lat), 128'd33);
        check("neg3x5_busy_cycles", 128'(bcnt), 128'd33);
        check("neg3x5_hi", 128'(hi32), 128'hFFFFFFFF);
        check("neg3x5_lo", 128'(lo32), 128'hFFFFFFF1);

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bcnt);
        check("ones_u_hi", 128'(hi32), 128'hFFFFFFFE);
        check("ones_u_lo", 128'(lo32), 128'h1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, bcnt);
        check("ones_s_hi", 128'(hi32), 128'h0);
        check("ones_s_lo", 128'(lo32), 128'h1);

        run_op(32'h80000000, 32'h80000000, 1'b1, lat, bcnt);
        check("min_s_hi", 128'(hi32), 128'h40000000);
        check("min_s_lo", 128'(lo32), 128'h0);

        // Start held high, operands/mode scrambled mid-run, then restarted on the done cycle.
        a_bus = 32'h80000000; b_bus = 32'h80000000; is_signed = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 6; i++) begin
            a_bus = $urandom; b_bus = $urandom; is_signed = 1'($urandom);
            @(posedge clk); #2;
        end
        lat = 6; bcnt = 0;
        while (!done32 && lat < 100) begin
            @(posedge clk); #2;
            lat++;
        end
        check("held_latency", 128'(lat), 128'd33);
        check("held_hi", 128'(hi32), 128'h40000000);
        check("held_lo", 128'(lo32), 128'h0);
        a_bus = 32'd7; b_bus = 32'd6; is_signed = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("b2b_latency", 128'(lat), 128'd33);
        check("b2b_hi", 128'(hi32), 128'h0);
        check("b2b_lo", 128'(lo32), 128'd42);

        a_bus = 32'd123; b_bus = 32'd456; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #2; end
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        check("abort_busy", 128'(busy32), 128'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #2;
            if (done32) seen_done = 1'b1;
        end
        check("abort_no_done", 128'(seen_done), 128'd0);
        check("abort_hi", 128'(hi32), 128'h0);
        check("abort_lo", 128'(lo32), 128'd42);

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        check("idle_abort_blocks_start", 128'(busy32), 128'd0);

        a_bus = 32'd3; b_bus = 32'd3; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        reset = 1'b1;
        #1;
        check("midrun_reset_hi", 128'(hi32), 128'h0);
        check("midrun_reset_lo", 128'(lo32), 128'h0);
        check("midrun_reset_busy", 128'(busy32), 128'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            case ($urandom % 4)
                0: a_bus = 32'hFFFFFFFF;
                1: a_bus = 32'h80000082;
                default: a_bus = $urandom;
            endcase
            case ($urandom % 4)
                0: b_bus = 32'h7FFFFF7F;
                1: b_bus = 32'h80000080;
                default: b_bus = $urandom;
            endcase
            is_signed = 1'($urandom);
            start = ($urandom % 3) == 0;
            abort = ($urandom % 60) == 0;
            @(posedge clk); #2;
        end
        start = 1'b0; abort = 1'b0;
        repeat (40) begin @(posedge clk); #2; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
